// File: rtl/fpu_mult_iter.sv
// Iterative signed/unsigned WIDTH x WIDTH multiplier, BITS_PER_CYC multiplier bits per cycle.
// Start/busy/done handshake; fpuhold freezes every register.
module fpu_mult_iter #(
    parameter int WIDTH        = 32,
    parameter int BITS_PER_CYC = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fpuhold,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] ma,
    input  logic [WIDTH-1:0] mb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic             movf
);

    localparam int N  = WIDTH / BITS_PER_CYC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;

    generate
        if (WIDTH % BITS_PER_CYC != 0) begin : g_bad_cfg
            $error("fpu_mult_iter: WIDTH must be a multiple of BITS_PER_CYC");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [PW-1:0]    r_acc, w_acc_nxt;
    logic [PW-1:0]    r_mcand, w_mcand_nxt;
    logic [WIDTH-1:0] r_mplier, w_mplier_nxt;
    logic             r_neg, w_neg_nxt;
    logic             r_sgn, w_sgn_nxt;
    logic [WIDTH-1:0] r_hi, w_hi_nxt;
    logic [WIDTH-1:0] r_lo, w_lo_nxt;
    logic             r_movf, w_movf_nxt;

    logic [WIDTH-1:0] w_ma_mag, w_mb_mag;
    logic [PW-1:0]    w_pp, w_sum, w_prod;
    logic [WIDTH-1:0] w_phi, w_plo;
    logic             w_povf;

    assign w_ma_mag = (is_signed & ma[WIDTH-1]) ? -ma : ma;
    assign w_mb_mag = (is_signed & mb[WIDTH-1]) ? -mb : mb;

    // Multiplicand is pre-shifted each step, so the slice weight is implicit.
    assign w_pp  = r_mcand * {{(PW-BITS_PER_CYC){1'b0}}, r_mplier[BITS_PER_CYC-1:0]};
    assign w_sum = r_acc + w_pp;
    assign w_prod = r_neg ? -w_sum : w_sum;
    assign w_phi  = w_prod[PW-1:WIDTH];
    assign w_plo  = w_prod[WIDTH-1:0];
    assign w_povf = r_sgn ? (w_phi != {WIDTH{w_plo[WIDTH-1]}})
                          : (w_phi != '0);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_acc_nxt    = r_acc;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_neg_nxt    = r_neg;
        w_sgn_nxt    = r_sgn;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_movf_nxt   = r_movf;
        if (!fpuhold) begin
            if (start && (r_state != S_RUN)) begin
                w_state_nxt  = S_RUN;
                w_cnt_nxt    = CW'(N - 1);
                w_acc_nxt    = '0;
                w_mcand_nxt  = {{WIDTH{1'b0}}, w_ma_mag};
                w_mplier_nxt = w_mb_mag;
                w_neg_nxt    = is_signed & (ma[WIDTH-1] ^ mb[WIDTH-1]);
                w_sgn_nxt    = is_signed;
            end else begin
                unique case (r_state)
                    S_RUN: begin
                        w_acc_nxt    = w_sum;
                        w_mcand_nxt  = r_mcand << BITS_PER_CYC;
                        w_mplier_nxt = r_mplier >> BITS_PER_CYC;
                        w_cnt_nxt    = r_cnt - 1'b1;
                        if (r_cnt == '0) begin
                            w_state_nxt = S_DONE;
                            w_hi_nxt    = w_phi;
                            w_lo_nxt    = w_plo;
                            w_movf_nxt  = w_povf;
                        end
                    end
                    S_DONE:  w_state_nxt = S_IDLE;
                    default: w_state_nxt = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_sgn    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_movf   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_acc    <= w_acc_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_neg    <= w_neg_nxt;
            r_sgn    <= w_sgn_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_movf   <= w_movf_nxt;
        end
    end

    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign prod_hi = r_hi;
    assign prod_lo = r_lo;
    assign movf    = r_movf;

endmodule

// File: tb/tb_fpu_mult_iter.sv
// Randomized self-checking bench for fpu_mult_iter (B=8 main instance, B=1 side instance).
// Expected products come from native 64-bit arithmetic.
module tb_fpu_mult_iter;

    logic        clk = 1'b0;
    logic        reset, fpuhold, start, is_signed;
    logic [31:0] ma, mb;
    logic        busy, done, movf;
    logic [31:0] prod_hi, prod_lo;

    logic        fpuhold1, start1, sgn1;
    logic [31:0] ma1, mb1;
    logic        busy1, done1, movf1;
    logic [31:0] hi1, lo1;

    int errors = 0;
    int checks = 0;

    fpu_mult_iter #(.WIDTH(32), .BITS_PER_CYC(8)) dut (
        .clk(clk), .reset(reset), .fpuhold(fpuhold), .start(start),
        .is_signed(is_signed), .ma(ma), .mb(mb), .busy(busy), .done(done),
        .prod_hi(prod_hi), .prod_lo(prod_lo), .movf(movf)
    );

    fpu_mult_iter #(.WIDTH(32), .BITS_PER_CYC(1)) dut1 (
        .clk(clk), .reset(reset), .fpuhold(fpuhold1), .start(start1),
        .is_signed(sgn1), .ma(ma1), .mb(mb1), .busy(busy1), .done(done1),
        .prod_hi(hi1), .prod_lo(lo1), .movf(movf1)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic s, output logic [63:0] p,
                                  output logic ov);
        longint sp;
        if (s) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            p  = sp;
            ov = (sp < -64'sd2147483648) || (sp > 64'sd2147483647);
        end else begin
            p  = {32'b0, a} * {32'b0, b};
            ov = (p > 64'h0000_0000_FFFF_FFFF);
        end
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h1;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Leaves the caller 1 time unit into the first RUN cycle.
    task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        ma = a; mb = b; is_signed = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ma = $urandom(); mb = $urandom(); is_signed = 1'($urandom());
    endtask

    // Counts negedges (current cycle = 1) until done; lat = -1 on timeout.
    task automatic wait_done(input int limit, output int lat, output int nobusy);
        lat = 0;
        nobusy = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            lat++;
            if (done) return;
            if (!busy) nobusy++;
        end
        lat = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, movf, prod_hi, prod_lo} !== '0) begin
            errors++;
            $display("FAIL reset_b8: got busy=%b done=%b movf=%b hi=%h lo=%h, want all 0",
                     busy, done, movf, prod_hi, prod_lo);
        end
        checks++;
        if ({busy1, done1, movf1, hi1, lo1} !== '0) begin
            errors++;
            $display("FAIL reset_b1: got busy=%b done=%b movf=%b hi=%h lo=%h, want all 0",
                     busy1, done1, movf1, hi1, lo1);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] ta [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000};
        logic [31:0] tb [3] = '{32'hFFFF_FFFF, 32'h0000_0007, 32'h8000_0000};
        logic        ts [3] = '{1'b0, 1'b1, 1'b1};
        logic [63:0] p;
        logic        ov;
        int          lat, nb;
        for (int i = 0; i < 3; i++) begin
            model(ta[i], tb[i], ts[i], p, ov);
            drive_start(ta[i], tb[i], ts[i]);
            wait_done(20, lat, nb);
            checks++;
            if (lat !== 5 || nb !== 0) begin
                errors++;
                $display("FAIL directed%0d_timing: got lat=%0d nobusy=%0d, want lat=5 nobusy=0",
                         i, lat, nb);
            end
            checks++;
            if ({prod_hi, prod_lo, movf} !== {p, ov}) begin
                errors++;
                $display("FAIL directed%0d_result: got %h_%h movf=%b, want %h movf=%b",
                         i, prod_hi, prod_lo, movf, p, ov);
            end
            @(negedge clk);
            checks++;
            if ({done, busy} !== 2'b00) begin
                errors++;
                $display("FAIL directed%0d_idle: got done=%b busy=%b, want 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic        s, ov;
        logic [63:0] p;
        int          lat, nb;
        for (int i = 0; i < 40; i++) begin
            a = pick();
            b = pick();
            s = 1'($urandom());
            model(a, b, s, p, ov);
            drive_start(a, b, s);
            wait_done(20, lat, nb);
            checks++;
            if (lat !== 5 || nb !== 0) begin
                errors++;
                $display("FAIL random%0d_timing: got lat=%0d nobusy=%0d, want lat=5 nobusy=0",
                         i, lat, nb);
            end
            checks++;
            if ({prod_hi, prod_lo, movf} !== {p, ov}) begin
                errors++;
                $display("FAIL random%0d: a=%h b=%h s=%b got %h_%h movf=%b, want %h movf=%b",
                         i, a, b, s, prod_hi, prod_lo, movf, p, ov);
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] a, b;
        logic [63:0] p;
        logic        ov;
        int          lat, nb, held_bad;
        a = $urandom();
        b = $urandom();
        model(a, b, 1'b1, p, ov);
        drive_start(a, b, 1'b1);
        @(posedge clk);
        #1;
        fpuhold = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        fpuhold = 1'b0;
        wait_done(20, lat, nb);
        checks++;
        if (lat !== 4 || nb !== 0) begin
            errors++;
            $display("FAIL hold_run_latency: got lat=%0d nobusy=%0d, want lat=4 nobusy=0",
                     lat, nb);
        end
        checks++;
        if ({prod_hi, prod_lo, movf} !== {p, ov}) begin
            errors++;
            $display("FAIL hold_run_result: got %h_%h movf=%b, want %h movf=%b",
                     prod_hi, prod_lo, movf, p, ov);
        end
        fpuhold = 1'b1;
        start = 1'b1;
        ma = 32'h5;
        mb = 32'h9;
        held_bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!done || busy || {prod_hi, prod_lo} !== p) held_bad++;
        end
        fpuhold = 1'b0;
        start = 1'b0;
        checks++;
        if (held_bad !== 0) begin
            errors++;
            $display("FAIL hold_done_pulse: got %0d bad held cycles, want 0", held_bad);
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL hold_release: got done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_start_during_run();
        logic [31:0] a, b;
        logic [63:0] p;
        logic        ov;
        int          lat, nb;
        a = $urandom();
        b = $urandom();
        model(a, b, 1'b0, p, ov);
        drive_start(a, b, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b1;
        ma = 32'h3;
        mb = 32'h3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(20, lat, nb);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL run_start_latency: got lat=%0d, want 3", lat);
        end
        checks++;
        if ({prod_hi, prod_lo, movf} !== {p, ov}) begin
            errors++;
            $display("FAIL run_start_result: got %h_%h movf=%b, want %h movf=%b",
                     prod_hi, prod_lo, movf, p, ov);
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL run_start_noqueue: got done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, c, d;
        logic [63:0] p1, p2;
        logic        ov1, ov2;
        int          lat, nb;
        a = $urandom(); b = $urandom(); c = pick(); d = pick();
        model(a, b, 1'b1, p1, ov1);
        model(c, d, 1'b0, p2, ov2);
        drive_start(a, b, 1'b1);
        wait_done(20, lat, nb);
        ma = c; mb = d; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || {prod_hi, prod_lo, movf} !== {p1, ov1}) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b done=%b %h_%h, want busy=1 done=0 %h",
                     busy, done, prod_hi, prod_lo, p1);
        end
        wait_done(20, lat, nb);
        checks++;
        if (lat !== 5 || nb !== 0) begin
            errors++;
            $display("FAIL b2b_latency: got lat=%0d nobusy=%0d, want lat=5 nobusy=0", lat, nb);
        end
        checks++;
        if ({prod_hi, prod_lo, movf} !== {p2, ov2}) begin
            errors++;
            $display("FAIL b2b_result: got %h_%h movf=%b, want %h movf=%b",
                     prod_hi, prod_lo, movf, p2, ov2);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, nb, seen;
        drive_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(20, lat, nb);
        drive_start(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, movf, prod_hi, prod_lo} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%b done=%b movf=%b hi=%h lo=%h, want all 0",
                     busy, done, movf, prod_hi, prod_lo);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d active cycles after reset, want 0", seen);
        end
    endtask

    task automatic test_b1();
        int lat;
        @(negedge clk);
        ma1 = 32'h1234_5678; mb1 = 32'h10; sgn1 = 1'b0; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        ma1 = 32'h0; mb1 = 32'h0;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done1) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL b1_latency: got lat=%0d, want 33", lat);
        end
        checks++;
        if ({hi1, lo1, movf1} !== {32'h1, 32'h2345_6780, 1'b1}) begin
            errors++;
            $display("FAIL b1_result: got %h_%h movf=%b, want 00000001_23456780 movf=1",
                     hi1, lo1, movf1);
        end
    endtask

    initial begin
        reset = 1'b1; fpuhold = 1'b0; start = 1'b0; is_signed = 1'b0;
        ma = '0; mb = '0;
        fpuhold1 = 1'b0; start1 = 1'b0; sgn1 = 1'b0; ma1 = '0; mb1 = '0;
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid_run();
        test_b1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
